// File: rtl/arbiter_main_pkg.sv
// Shared constants for the issue-queue request arbiter.
// NONE is the index reported when no requester is granted.
package arbiter_main_pkg;

    localparam int ARB_N     = 16;
    localparam int ARB_IDX_W = $clog2(ARB_N + 1);
    localparam int ARB_NONE  = ARB_N;

endpackage

// File: rtl/arbiter_main_if.sv
// Request/grant bundle between a requester vector and the arbiter.
// master drives the requests, slave returns the pick.
interface arbiter_main_if
    import arbiter_main_pkg::*;
#(
    parameter int N     = ARB_N,
    parameter int IDX_W = ARB_IDX_W
);

    logic [N-1:0]     ready;
    logic [N-1:0]     grant;
    logic [IDX_W-1:0] granted;

    modport master (
        output ready,
        input  grant,
        input  granted
    );

    modport slave (
        input  ready,
        output grant,
        output granted
    );

endinterface

// File: rtl/arb_prio_enc.sv
// Find-first-set over N bits, lowest index wins.
// Returns one-hot pick, its index (N when empty) and a found flag.
module arb_prio_enc #(
    parameter int N     = 16,
    parameter int IDX_W = $clog2(N + 1)
) (
    input  logic [N-1:0]     req,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Bits above the winner are gated by found, so they never reach the outputs.
    always_comb begin
        onehot = '0;
        idx    = IDX_W'(N);
        found  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                onehot[i] = 1'b1;
                idx       = IDX_W'(i);
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbiter_main.sv
// N-way arbiter: fixed priority or rotating priority from a pointer.
// Zero-latency outputs; only the pointer is registered.
module arbiter_main
    import arbiter_main_pkg::*;
#(
    parameter int N           = ARB_N,
    parameter int IDX_W       = $clog2(N + 1),
    parameter int ROUND_ROBIN = 0
) (
    input  logic         CLK,
    input  logic         RESET,
    arbiter_main_if.slave arb
);

    localparam logic [IDX_W-1:0] NONE_IDX = IDX_W'(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [IDX_W:0]   N_WIDE   = (IDX_W + 1)'(N);

    logic [IDX_W-1:0] ptr;
    logic [2*N-1:0]   req2;
    logic [2*N-1:0]   oh2;
    logic [N-1:0]     rot_req;
    logic [N-1:0]     rot_oh;
    logic [IDX_W-1:0] rot_idx;
    logic             rot_found;
    logic [IDX_W:0]   idx_sum;

    // Rotate right by ptr so the search starts at the pointer.
    always_comb begin
        req2    = {arb.ready, arb.ready} >> ptr;
        rot_req = req2[N-1:0];
    end

    arb_prio_enc #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_enc (
        .req    (rot_req),
        .onehot (rot_oh),
        .idx    (rot_idx),
        .found  (rot_found)
    );

    always_comb begin
        oh2     = {rot_oh, rot_oh} << ptr;
        idx_sum = {1'b0, rot_idx} + {1'b0, ptr};
        if (idx_sum >= N_WIDE) begin
            idx_sum = idx_sum - N_WIDE;
        end
        arb.grant   = oh2[2*N-1:N];
        arb.granted = rot_found ? idx_sum[IDX_W-1:0] : NONE_IDX;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ptr <= '0;
        end else if (ROUND_ROBIN != 0 && rot_found) begin
            ptr <= (arb.granted == LAST_IDX) ? '0 : arb.granted + 1'b1;
        end
    end

endmodule

// File: tb/tb_arbiter_main.sv
// Bench for arbiter_main: fixed and round-robin instances side by side,
// checked every cycle against a scan-order reference plus literal cases.
module tb_arbiter_main;

    localparam int N     = 16;
    localparam int IDX_W = 5;

    logic         CLK;
    logic         RESET;
    logic [N-1:0] ready;

    int n_pass  = 0;
    int n_total = 0;
    int mp      = 0;

    arbiter_main_if #(.N(N), .IDX_W(IDX_W)) if_fix ();
    arbiter_main_if #(.N(N), .IDX_W(IDX_W)) if_rr ();

    assign if_fix.ready = ready;
    assign if_rr.ready  = ready;

    arbiter_main #(.N(N), .IDX_W(IDX_W), .ROUND_ROBIN(0)) u_fix (
        .CLK   (CLK),
        .RESET (RESET),
        .arb   (if_fix.slave)
    );

    arbiter_main #(.N(N), .IDX_W(IDX_W), .ROUND_ROBIN(1)) u_rr (
        .CLK   (CLK),
        .RESET (RESET),
        .arb   (if_rr.slave)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic int first_from(input logic [N-1:0] v, input int start);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (start + k) % N;
            if (v[j] === 1'b1) return j;
        end
        return N;
    endfunction

    function automatic int onehot_of(input int w);
        return (w < N) ? (1 << w) : 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference pointer: next start after the last winner, 0 in reset.
    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            mp = 0;
        end else begin
            int w;
            w = first_from(ready, mp);
            if (w != N) mp = (w + 1) % N;
        end
    end

    always @(negedge CLK) begin
        int wf;
        int wr;
        wf = first_from(ready, 0);
        wr = first_from(ready, mp);
        check("fix_granted", int'(if_fix.granted), wf);
        check("fix_grant", int'(if_fix.grant), onehot_of(wf));
        check("rr_granted", int'(if_rr.granted), wr);
        check("rr_grant", int'(if_rr.grant), onehot_of(wr));
    end

    task automatic drive(input logic [N-1:0] v);
        @(posedge CLK);
        #2;
        ready = v;
        #1;
    endtask

    initial begin
        logic [N-1:0] r;
        RESET = 1'b0;
        ready = '0;
        #1;
        check("rst_fix_granted", int'(if_fix.granted), 16);
        check("rst_rr_grant", int'(if_rr.grant), 0);
        ready = 16'hFFFF;
        #1;
        check("rst_rr_full", int'(if_rr.granted), 0);
        ready = '0;
        @(negedge CLK);
        RESET = 1'b1;

        drive(16'h0000);
        check("empty_fix_granted", int'(if_fix.granted), 16);
        check("empty_fix_grant", int'(if_fix.grant), 0);
        check("empty_rr_granted", int'(if_rr.granted), 16);

        drive(16'hFFFF);
        check("full_fix_granted", int'(if_fix.granted), 0);
        check("rr_seq_0", int'(if_rr.granted), 0);
        for (int k = 1; k <= 16; k++) begin
            @(posedge CLK);
            #3;
            check($sformatf("rr_seq_%0d", k), int'(if_rr.granted), k % 16);
        end

        drive(16'hA0C0);
        check("fix_a0c0_grant", int'(if_fix.grant), 16'h0040);
        check("fix_a0c0_granted", int'(if_fix.granted), 6);
        drive(16'h8000);
        check("fix_8000_grant", int'(if_fix.grant), 16'h8000);
        check("fix_8000_granted", int'(if_fix.granted), 15);

        drive(16'h0010);
        check("rr_set_p5", int'(if_rr.granted), 4);
        drive(16'h0011);
        check("rr_p5_granted", int'(if_rr.granted), 0);
        check("rr_p5_grant", int'(if_rr.grant), 16'h0001);
        @(posedge CLK);
        #3;
        check("rr_p1_granted", int'(if_rr.granted), 4);
        RESET = 1'b0;
        #1;
        check("rr_midrst_granted", int'(if_rr.granted), 0);
        check("rr_midrst_grant", int'(if_rr.grant), 16'h0001);
        @(posedge CLK);
        #2;
        RESET = 1'b1;

        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 4))
                0: r = '0;
                1: r = N'(1) << $urandom_range(0, N - 1);
                2: r = N'($urandom) & N'($urandom) & N'($urandom);
                3: r = N'($urandom) & N'($urandom);
                default: r = N'($urandom);
            endcase
            drive(r);
        end

        @(negedge CLK);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
